// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the single-lane SPI master.
package spi_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOW,
      HIGH,
      HOLD,
      DONE
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int LEN_W      = $clog2(DEF_DATA_W) + 1;

   // Requested bit counts beyond the word width run as full-width transfers.
   function automatic int clamp_len(input int len, input int max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// Half-period counter: latches the divider on start, reloads on every phase
// entry and flags the last cycle of a phase with tick; it owns no sck edges.
module spi_master_clkgen #(
   parameter int DIV_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_q <= '0;
         cnt   <= '0;
      end else if (start) begin
         div_q <= div;
         cnt   <= div;
      end else if (load) begin
         cnt   <= div_q;
      end else if (cnt != '0) begin
         cnt   <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master_lite.sv
// SPI master, sck idle low, mosi/miso updated and sampled at sck fall.
// Optional LSB-first transfers: define SPI_MASTER_LSB_FIRST_EN (adds cmd_lsb).
module spi_master_lite
   import spi_master_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  SS_W   = 8,
   parameter int  DIV_W  = 8,
   localparam int LW     = $clog2(DATA_W) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [LW-1:0]     cmd_len,
   input  logic [SS_W-1:0]   cmd_ss,
`ifdef SPI_MASTER_LSB_FIRST_EN
   input  logic              cmd_lsb,
`endif
   input  logic [DIV_W-1:0]  cfg_div,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              sck,
   output logic [SS_W-1:0]   ss,
   output logic              mosi,
   input  logic              miso
);

   localparam int IW = $clog2(DATA_W);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] rx_next;
   logic [LW-1:0]     bits_q;
   logic [LW-1:0]     len_c;
   logic [IW-1:0]     idx_q;
   logic [IW-1:0]     idx_next;
   logic [IW-1:0]     first_idx;
   logic              accept;
   logic              phase_end;
   logic              tick;
`ifdef SPI_MASTER_LSB_FIRST_EN
   logic              lsb_q;
`endif

   assign len_c = LW'(clamp_len(int'(cmd_len), DATA_W));

   spi_master_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .clock (clock),
      .reset (reset),
      .start (accept),
      .load  (phase_end),
      .div   (cfg_div),
      .tick  (tick)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      accept    = 1'b0;
      phase_end = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = (len_c == '0) ? DONE : LOW;
            end
         end
         LOW: if (tick) begin
            phase_end = 1'b1;
            state_d   = HIGH;
         end
         HIGH: if (tick) begin
            phase_end = 1'b1;
            state_d   = (bits_q == LW'(1)) ? HOLD : LOW;
         end
         HOLD: if (tick) begin
            phase_end = 1'b1;
            state_d   = DONE;
         end
         DONE: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
`ifdef SPI_MASTER_LSB_FIRST_EN
      first_idx = cmd_lsb ? '0 : IW'(len_c - LW'(1));
      idx_next  = lsb_q ? idx_q + 1'b1 : idx_q - 1'b1;
      rx_next   = lsb_q ? (rx_q | (DATA_W'(miso) << idx_q))
                        : {rx_q[DATA_W-2:0], miso};
`else
      first_idx = IW'(len_c - LW'(1));
      idx_next  = idx_q - 1'b1;
      rx_next   = {rx_q[DATA_W-2:0], miso};
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         rx_q    <= '0;
         bits_q  <= '0;
         idx_q   <= '0;
         sck     <= 1'b0;
         ss      <= '1;
         mosi    <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
         lsb_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q <= cmd_data;
            rx_q   <= '0;
            bits_q <= len_c;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q  <= cmd_lsb;
`endif
            if (len_c != '0) begin
               ss    <= ~cmd_ss;
               sck   <= 1'b0;
               idx_q <= first_idx;
               mosi  <= cmd_data[first_idx];
            end
         end
         if (phase_end) begin
            case (state_q)
               LOW:  sck <= 1'b1;
               HIGH: begin
                  // Falling edge: capture miso and present the next bit together.
                  sck    <= 1'b0;
                  rx_q   <= rx_next;
                  bits_q <= bits_q - 1'b1;
                  if (bits_q != LW'(1)) begin
                     idx_q <= idx_next;
                     mosi  <= data_q[idx_next];
                  end
               end
               HOLD: ss <= '1;
               default: ;
            endcase
         end
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = rx_q;

endmodule

// File: tb/tb_spi_master_lite.sv
// Randomized/directed bench for spi_master_lite against a bit-sequence model,
// with loopback and a bit-reversal slave on miso.
module tb_spi_master_lite;
   import spi_master_pkg::*;

   localparam int DW = 32;
   localparam int SW = 8;
   localparam int VW = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [DW-1:0]   cmd_data = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic [SW-1:0]   cmd_ss = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
   logic            cmd_lsb = 1'b0;
`endif
   logic [VW-1:0]   cfg_div = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [DW-1:0]   rsp_data;
   logic            sck;
   logic [SW-1:0]   ss;
   logic            mosi;
   logic            miso;

   bit              rev_mode = 1'b0;
   logic            rev_miso = 1'b0;
   logic [7:0]      rev_byte = '0;
   int              rev_cnt = 0;

   int              n_assert = 0;
   int              n_fail = 0;
   int              rise_cnt = 0;
   int              fall_cnt = 0;
   int              idle_edges = 0;
   logic            sck_prev = 1'b0;

   always #5 clock = ~clock;

   assign miso = rev_mode ? rev_miso : mosi;

   spi_master_lite #(.DATA_W(DW), .SS_W(SW), .DIV_W(VW)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .cmd_ss    (cmd_ss),
`ifdef SPI_MASTER_LSB_FIRST_EN
      .cmd_lsb   (cmd_lsb),
`endif
      .cfg_div   (cfg_div),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .sck       (sck),
      .ss        (ss),
      .mosi      (mosi),
      .miso      (miso)
   );

   // Bit-reversal slave: takes one byte, then returns it reversed, MSB-first.
   always @(posedge sck or posedge ss[0]) begin
      if (ss[0] === 1'b1) begin
         rev_cnt  = 0;
         rev_miso = 1'b0;
      end else if (rev_mode) begin
         if (rev_cnt < 8) rev_byte = {rev_byte[6:0], mosi};
         else if (rev_cnt < 16) rev_miso = rev_byte[rev_cnt-8];
         rev_cnt++;
      end
   end

   always @(negedge clock) begin
      if (sck === 1'b1 && sck_prev === 1'b0) rise_cnt++;
      if (sck === 1'b0 && sck_prev === 1'b1) fall_cnt++;
      if (sck !== sck_prev && ss === '1) idle_edges++;
      sck_prev = sck;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected response from the order bits travel on the wire.
   function automatic logic [31:0] model_rx(input logic [31:0] data, input int lc,
                                            input bit lsb, input bit rev);
      bit          tx [32];
      bit          rx [32];
      logic [31:0] w = '0;
      for (int k = 0; k < lc; k++) tx[k] = lsb ? data[k] : data[lc-1-k];
      for (int k = 0; k < lc; k++)
         rx[k] = !rev ? tx[k] : ((k >= 8 && k < 16) ? tx[15-k] : 1'b0);
      for (int k = 0; k < lc; k++)
         if (lsb) w[k] = rx[k];
         else     w[lc-1-k] = rx[k];
      return w;
   endfunction

   task automatic run_xfer(input string tag, input logic [31:0] data, input int len,
                           input int div, input logic [7:0] mask, input bit lsb,
                           input int hold, input bit rev, output int lat,
                           output logic [31:0] rsp, output logic first_mosi);
      int          lc, exp_lat, r0, f0, i0, ss_bad, stall_bad, cyc;
      logic [7:0]  exp_ss;
      logic [31:0] exp_rsp;
      lc      = (len > DW) ? DW : len;
      exp_lat = (lc == 0) ? 1 : 1 + (2 * lc + 1) * (div + 1);
      exp_rsp = model_rx(data, lc, lsb, rev);
      rev_mode  = rev;
      cmd_data  = data;
      cmd_len   = LEN_W'(len);
      cmd_ss    = mask;
      cfg_div   = VW'(div);
`ifdef SPI_MASTER_LSB_FIRST_EN
      cmd_lsb   = lsb;
`endif
      cmd_valid = 1'b1;
      cyc = 0;
      while (cmd_ready !== 1'b1 && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      check({tag, "/accept"}, 64'(cmd_ready), 64'd1);
      r0 = rise_cnt;
      f0 = fall_cnt;
      i0 = idle_edges;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      cmd_len   = LEN_W'($urandom);
      cmd_ss    = SW'($urandom);
      cfg_div   = VW'($urandom);
      lat = 1;
      ss_bad = 0;
      first_mosi = 1'b0;
      while (1) begin
         @(negedge clock);
         exp_ss = (lc != 0 && lat < exp_lat) ? ~mask : 8'hFF;
         if (ss !== exp_ss) ss_bad++;
         if (lat == div + 2) first_mosi = mosi;
         if (rsp_valid === 1'b1 || lat >= 4000) break;
         @(posedge clock);
         lat++;
      end
      rsp = rsp_data;
      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/rsp_data"}, 64'(rsp), 64'(exp_rsp));
      check({tag, "/ss_cycles_wrong"}, 64'(ss_bad), 64'd0);
      check({tag, "/sck_rises"}, 64'(rise_cnt - r0), 64'(lc));
      check({tag, "/sck_falls"}, 64'(fall_cnt - f0), 64'(lc));
      if (mask != 8'h00) check({tag, "/edges_ss_high"}, 64'(idle_edges - i0), 64'd0);
      stall_bad = 0;
      if (hold > 0) begin
         cmd_valid = 1'b1;
         cmd_data  = $urandom;
         cmd_len   = LEN_W'($urandom_range(1, DW));
         cmd_ss    = SW'($urandom);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (rsp_valid !== 1'b1 || rsp_data !== rsp || cmd_ready !== 1'b0) stall_bad++;
      end
      if (hold > 0) check({tag, "/stall_unstable"}, 64'(stall_bad), 64'd0);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      rev_mode  = 1'b0;
      @(negedge clock);
      check({tag, "/rsp_valid_after_hs"}, 64'(rsp_valid), 64'd0);
      check({tag, "/cmd_ready_after_hs"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, cyc, f0, cnt;
      logic [31:0] rsp;
      logic        fm;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset/sck", 64'(sck), 64'd0);
      check("reset/ss", 64'(ss), 64'hFF);
      check("reset/mosi", 64'(mosi), 64'd0);
      check("reset/cmd_ready", 64'(cmd_ready), 64'd1);
      check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset/rsp_data", 64'(rsp_data), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      run_xfer("loop_a5", 32'hA5, 8, 0, 8'h01, 1'b0, 0, 1'b0, lat, rsp, fm);
      check("loop_a5/lat18", 64'(lat), 64'd18);
      check("loop_a5/data", 64'(rsp), 64'hA5);

      // Abort after the third falling edge of a len=8, div=2 transfer.
      cmd_data  = $urandom;
      cmd_len   = LEN_W'(8);
      cmd_ss    = 8'h01;
      cfg_div   = VW'(2);
      cmd_valid = 1'b1;
      cyc = 0;
      while (cmd_ready !== 1'b1 && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      f0 = fall_cnt;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cyc = 0;
      while (fall_cnt - f0 < 3 && cyc < 500) begin
         @(negedge clock);
         cyc++;
      end
      check("abort/reached_bit3", 64'(fall_cnt - f0), 64'd3);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("abort/sck", 64'(sck), 64'd0);
      check("abort/ss", 64'(ss), 64'hFF);
      check("abort/rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort/cmd_ready", 64'(cmd_ready), 64'd1);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0 || sck !== 1'b0 || ss !== 8'hFF) cnt++;
      end
      check("abort/stays_idle", 64'(cnt), 64'd0);

      run_xfer("bitrev", 32'h1200, 16, 1, 8'h01, 1'b0, 0, 1'b1, lat, rsp, fm);
      check("bitrev/low_byte", 64'(rsp[7:0]), 64'h48);

      run_xfer("len0", $urandom, 0, 2, 8'h3C, 1'b0, 0, 1'b0, lat, rsp, fm);
      run_xfer("len40", $urandom, 40, 1, 8'h80, 1'b0, 0, 1'b0, lat, rsp, fm);
      run_xfer("backpressure", $urandom, 12, 1, 8'h02, 1'b0, 5, 1'b0, lat, rsp, fm);
      run_xfer("mask0", $urandom, 10, 0, 8'h00, 1'b0, 0, 1'b0, lat, rsp, fm);

`ifdef SPI_MASTER_LSB_FIRST_EN
      run_xfer("lsb_01", 32'h01, 8, 0, 8'h01, 1'b1, 0, 1'b0, lat, rsp, fm);
      check("lsb_01/first_high_mosi", 64'(fm), 64'd1);
      check("lsb_01/data", 64'(rsp), 64'h01);
      run_xfer("lsb_bitrev", 32'h0048, 16, 0, 8'h04, 1'b1, 1, 1'b1, lat, rsp, fm);
`endif

      for (int t = 0; t < 24; t++) begin
         int         len_r, div_r, hold_r;
         logic [7:0] m;
         bit         l;
         len_r  = $urandom_range(0, 40);
         div_r  = $urandom_range(0, 3);
         hold_r = $urandom_range(0, 3);
         m      = 8'($urandom_range(1, 255));
         l      = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
         l      = 1'($urandom_range(0, 1));
`endif
         run_xfer($sformatf("rnd%0d", t), $urandom, len_r, div_r, m, l, hold_r,
                  1'b0, lat, rsp, fm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
